// File: rtl/pwm_multich_pkg.sv
// Shared constants, config-decode type and duty slew helper for pwm_multich_gen.
package pwm_multich_pkg;

  // Config address map: period, ramp step, then one duty target per channel.
  localparam int unsigned ADDR_PERIOD    = 0;
  localparam int unsigned ADDR_RAMP      = 1;
  localparam int unsigned ADDR_DUTY_BASE = 2;

  // Reset period (counter max): 25 Hz from the 25 MHz board clock.
  localparam int unsigned DEF_PERIOD = 999_999;

  // Working width of the slew helper; channel values are zero-extended into it.
  localparam int unsigned SLEW_W = 32;

  typedef logic [SLEW_W-1:0] slew_val_t;

  // Classification of one config write.
  typedef enum logic [1:0] {
    CFG_NONE   = 2'd0,
    CFG_PERIOD = 2'd1,
    CFG_RAMP   = 2'd2,
    CFG_DUTY   = 2'd3
  } cfg_kind_e;

  // Next active duty: jump straight to the target when step is 0, otherwise
  // move toward it by at most step without overshooting. The difference is
  // held one bit wider so it can never wrap.
  function automatic slew_val_t slew_next(input slew_val_t act,
                                          input slew_val_t tgt,
                                          input slew_val_t step);
    logic [SLEW_W:0] diff;
    slew_val_t       res;
    res  = tgt;
    diff = '0;
    if (step != '0) begin
      if (tgt >= act) begin
        diff = {1'b0, tgt} - {1'b0, act};
        if (diff > {1'b0, step}) res = act + step;
      end else begin
        diff = {1'b0, act} - {1'b0, tgt};
        if (diff > {1'b0, step}) res = act - step;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_ch_slew.sv
// One PWM channel: double-buffered duty (target + active), optional slew of
// the active duty at period boundaries, and the registered output compare.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   tgt_we       - store tgt_wdata into the duty target on this edge
//   tgt_wdata    - new duty target
//   boundary     - current cycle is the last count of the period
//   ramp_step    - slew step (0 = immediate load)
//   cnt          - shared period counter value
//   en           - channel enable, level sensitive
//   pwm          - registered PWM output
module pwm_ch_slew
  import pwm_multich_pkg::*;
#(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_we,
  input  logic [CNT_W-1:0] tgt_wdata,
  input  logic             boundary,
  input  logic [CNT_W-1:0] ramp_step,
  input  logic [CNT_W-1:0] cnt,
  input  logic             en,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_tgt_q, duty_tgt_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic             pwm_q, pwm_d;

  // Target capture, boundary load/slew and compare.
  // The boundary load reads duty_tgt_q, so a write landing on the boundary
  // edge is only seen at the following boundary.
  always_comb begin
    duty_tgt_d = duty_tgt_q;
    duty_act_d = duty_act_q;
    pwm_d      = 1'b0;

    if (tgt_we) begin
      duty_tgt_d = tgt_wdata;
    end

    if (boundary) begin
      duty_act_d = CNT_W'(slew_next(SLEW_W'(duty_act_q),
                                    SLEW_W'(duty_tgt_q),
                                    SLEW_W'(ramp_step)));
    end

    // duty 0 never matches; duty above the period max always matches.
    pwm_d = en & (cnt < duty_act_q);
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_tgt_q <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      duty_tgt_q <= duty_tgt_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multich_gen.sv
// Multi-channel PWM generator: one shared period counter, CH_NUM duty
// comparators, double-buffered period/duty that take effect only at period
// boundaries, and optional duty ramping (soft start/stop).
//
// Ports:
//   ext_clk_25m  - 25 MHz board clock
//   ext_rst      - asynchronous reset, active high
//   cfg_we       - config write strobe (one write per cycle)
//   cfg_addr     - 0 = period, 1 = ramp step, 2+i = duty target of channel i
//   cfg_wdata    - config write data
//   ch_en        - per-channel enable, level sensitive
//   o_pwm        - registered PWM outputs
//   period_tick  - one-cycle pulse aligned with cnt == 0
module pwm_multich_gen
  import pwm_multich_pkg::*;
#(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DEF_PERIOD = pwm_multich_pkg::DEF_PERIOD
) (
  input  logic              ext_clk_25m,
  input  logic              ext_rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  input  logic [CH_NUM-1:0] ch_en,
  output logic [CH_NUM-1:0] o_pwm,
  output logic              period_tick
);

  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEF_PERIOD);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_tgt_q, period_tgt_d;
  logic [CNT_W-1:0]  period_act_q, period_act_d;
  logic [CNT_W-1:0]  ramp_step_q, ramp_step_d;
  logic              period_tick_q, period_tick_d;

  logic              boundary;
  cfg_kind_e         cfg_kind;
  logic [CH_NUM-1:0] duty_we;

  // Address decode; addresses past the last duty slot fall through to NONE.
  always_comb begin
    cfg_kind = CFG_NONE;
    duty_we  = '0;
    if (cfg_we) begin
      if (cfg_addr == ADDR_W'(ADDR_PERIOD)) begin
        cfg_kind = CFG_PERIOD;
      end else if (cfg_addr == ADDR_W'(ADDR_RAMP)) begin
        cfg_kind = CFG_RAMP;
      end else begin
        for (int unsigned i = 0; i < CH_NUM; i++) begin
          if (cfg_addr == ADDR_W'(ADDR_DUTY_BASE + i)) begin
            cfg_kind   = CFG_DUTY;
            duty_we[i] = 1'b1;
          end
        end
      end
    end
  end

  // Period counter, period shadow load, ramp step and tick.
  // period_act only changes at the boundary, so cnt can never be stranded
  // above a freshly shrunk period.
  always_comb begin
    boundary      = (cnt_q == period_act_q);
    cnt_d         = cnt_q + CNT_W'(1);
    period_act_d  = period_act_q;
    period_tgt_d  = period_tgt_q;
    ramp_step_d   = ramp_step_q;
    period_tick_d = boundary;

    if (boundary) begin
      cnt_d        = '0;
      period_act_d = period_tgt_q;
    end

    if (cfg_kind == CFG_PERIOD) begin
      period_tgt_d = cfg_wdata;
    end

    if (cfg_kind == CFG_RAMP) begin
      ramp_step_d = cfg_wdata;
    end
  end

  // Shared state registers.
  always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
    if (ext_rst) begin
      cnt_q         <= '0;
      period_tgt_q  <= PERIOD_RST;
      period_act_q  <= PERIOD_RST;
      ramp_step_q   <= '0;
      period_tick_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      period_tgt_q  <= period_tgt_d;
      period_act_q  <= period_act_d;
      ramp_step_q   <= ramp_step_d;
      period_tick_q <= period_tick_d;
    end
  end

  assign period_tick = period_tick_q;

  // Per-channel duty buffering, slew and output compare.
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    pwm_ch_slew #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (ext_clk_25m),
      .rst       (ext_rst),
      .tgt_we    (duty_we[i]),
      .tgt_wdata (cfg_wdata),
      .boundary  (boundary),
      .ramp_step (ramp_step_q),
      .cnt       (cnt_q),
      .en        (ch_en[i]),
      .pwm       (o_pwm[i])
    );
  end

endmodule

// File: tb/tb_pwm_multich_gen.sv
// Self-checking bench for pwm_multich_gen (CH_NUM=4, CNT_W=8, DEF_PERIOD=9).
module tb_pwm_multich_gen;

  localparam int unsigned CH = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned DP = 9;

  logic          clk;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic [CH-1:0] ch_en;
  logic [CH-1:0] o_pwm;
  logic          period_tick;

  pwm_multich_gen #(
    .CH_NUM     (CH),
    .CNT_W      (CW),
    .ADDR_W     (AW),
    .DEF_PERIOD (DP)
  ) dut (
    .ext_clk_25m (clk),
    .ext_rst     (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .ch_en       (ch_en),
    .o_pwm       (o_pwm),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Reference model state (plain integers).
  int m_cnt, m_per_tgt, m_per_act, m_ramp, m_tick;
  int m_tgt [CH];
  int m_act [CH];
  int m_pwm [CH];
  int hi    [CH];

  typedef struct {
    int ch;
    int duty;
    int exp_high;
  } vec_t;

  vec_t tbl [4];
  int   up   [5];
  int   down [4];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int slew_ref(input int act, input int tgt, input int step);
    int d, m;
    if (step == 0) return tgt;
    d = (tgt > act) ? tgt - act : act - tgt;
    m = (step < d) ? step : d;
    return (tgt > act) ? act + m : act - m;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_per_tgt = DP; m_per_act = DP; m_ramp = 0; m_tick = 0;
    for (int i = 0; i < CH; i++) begin
      m_tgt[i] = 0; m_act[i] = 0; m_pwm[i] = 0;
    end
  endtask

  // One clock edge of the specified behaviour, using the inputs present at the edge.
  task automatic model_step();
    int b, a;
    b = (m_cnt == m_per_act) ? 1 : 0;
    for (int i = 0; i < CH; i++)
      m_pwm[i] = (ch_en[i] && (m_cnt < m_act[i])) ? 1 : 0;
    m_tick = b;
    if (b != 0) begin
      m_per_act = m_per_tgt;
      for (int i = 0; i < CH; i++) m_act[i] = slew_ref(m_act[i], m_tgt[i], m_ramp);
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
    if (cfg_we) begin
      a = int'(cfg_addr);
      if (a == 0) m_per_tgt = int'(cfg_wdata);
      else if (a == 1) m_ramp = int'(cfg_wdata);
      else if (a < CH + 2) m_tgt[a-2] = int'(cfg_wdata);
    end
  endtask

  function automatic int model_pwm_vec();
    int v = 0;
    for (int i = 0; i < CH; i++) v = v | (m_pwm[i] << i);
    return v;
  endfunction

  // Advance one clock, update the model, compare away from the edge.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    chk("pwm_vs_model", int'(o_pwm), model_pwm_vec());
    chk("tick_vs_model", int'(period_tick), m_tick);
  endtask

  task automatic wr(input int a, input int d);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_wdata = CW'(d);
    cyc();
    cfg_we    = 1'b0;
  endtask

  // Cycles until the next period_tick sample (bounded).
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!period_tick && n < 300);
    if (!period_tick) chk("tick_timeout", int'(period_tick), 1);
  endtask

  // High-cycle count per channel over len samples.
  task automatic measure(input int len);
    for (int i = 0; i < CH; i++) hi[i] = 0;
    repeat (len) begin
      cyc();
      for (int i = 0; i < CH; i++) hi[i] += int'(o_pwm[i]);
    end
  endtask

  initial begin
    int n;
    tbl[0] = '{0, 3, 3};
    tbl[1] = '{1, 0, 0};
    tbl[2] = '{2, 10, 10};
    tbl[3] = '{3, 5, 5};
    up     = '{2, 4, 6, 7, 7};
    down   = '{5, 3, 1, 0};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; ch_en = '0;
    model_reset();
    cyc(); cyc();
    chk("reset_pwm", int'(o_pwm), 0);
    chk("reset_tick", int'(period_tick), 0);
    rst   = 1'b0;
    ch_en = '1;

    // 1: basic duties
    for (int i = 0; i < 4; i++) wr(2 + tbl[i].ch, tbl[i].duty);
    wait_tick(n);
    measure(10);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_high_ch%0d", tbl[i].ch), hi[tbl[i].ch], tbl[i].exp_high);
    chk("t1_tick_every_10", int'(period_tick), 1);

    // 2: shrink period mid-period
    repeat (7) cyc();
    wr(0, 4);
    wait_tick(n);
    chk("t2_current_period_runs_out", n, 2);
    wait_tick(n);
    chk("t2_gap_a", n, 5);
    wait_tick(n);
    chk("t2_gap_b", n, 5);

    // 3: ramping
    wr(0, 9);
    wr(2, 0);
    wait_tick(n);
    wr(1, 2);
    wr(2, 7);
    wait_tick(n);
    for (int k = 0; k < 5; k++) begin
      measure(10);
      chk($sformatf("t3_ramp_up_%0d", k), hi[0], up[k]);
    end
    wr(2, 0);
    wait_tick(n);
    for (int k = 0; k < 4; k++) begin
      measure(10);
      chk($sformatf("t3_ramp_down_%0d", k), hi[0], down[k]);
    end

    // 4: duty write on the boundary cycle
    wr(1, 0);
    wait_tick(n);
    repeat (9) cyc();
    wr(5, 2);
    chk("t4_write_on_boundary", int'(period_tick), 1);
    measure(10);
    chk("t4_old_duty_kept", hi[3], 5);
    measure(10);
    chk("t4_new_duty", hi[3], 2);

    // 5: ch_en drop and restore
    wr(3, 6);
    wait_tick(n);
    cyc(); cyc();
    chk("t5_high_before", int'(o_pwm[1]), 1);
    ch_en = 4'b1101;
    cyc();
    chk("t5_disabled_low", int'(o_pwm[1]), 0);
    chk("t5_ch2_unaffected", int'(o_pwm[2]), 1);
    cyc();
    ch_en = '1;
    cyc();
    chk("t5_reenabled_high", int'(o_pwm[1]), 1);
    cyc(); cyc();
    chk("t5_same_phase_fall", int'(o_pwm[1]), 0);

    // 6: async reset with outputs high
    rst = 1'b1;
    #1;
    chk("t6_async_pwm_low", int'(o_pwm), 0);
    chk("t6_async_tick_low", int'(period_tick), 0);
    model_reset();
    cyc(); cyc();
    rst = 1'b0;
    wait_tick(n);
    chk("t6_period_default", n, 10);
    measure(10);
    for (int i = 0; i < CH; i++) chk($sformatf("t6_duty_zero_ch%0d", i), hi[i], 0);
    wr(9, 55);
    wait_tick(n);
    chk("t6_bad_addr_period", n, 9);
    measure(10);
    for (int i = 0; i < CH; i++) chk($sformatf("t6_bad_addr_ch%0d", i), hi[i], 0);

    // Random traffic against the model
    repeat (3000) begin
      rst       = ($urandom_range(0, 299) == 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = AW'($urandom_range(0, 15));
      cfg_wdata = (cfg_addr < 2) ? CW'($urandom_range(0, 15)) : CW'($urandom_range(0, 20));
      if ($urandom_range(0, 9) == 0) ch_en = CH'($urandom);
      cyc();
    end
    rst    = 1'b0;
    cfg_we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
